pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enables and flushes of PC, IF/ID, ID/EX and EX/MEM.
- Drives a bubble control into MEM/WB. MEM/WB has no enable, so the bubble forces its RegWriteEN_In to 0.
- Resolves load-use hazards, branch flushes and multi-cycle data-memory waits, with a timeout guard on the memory handshake.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in MEM_WAIT before forced release.
- TMR_W, 8: width of the wait timer. Must satisfy 2^TMR_W > MEM_TIMEOUT.

Ports:
- CLOCK  in  1  pipeline clock.
- RESET_N  in  1  reset.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  load destination register.
- IFID_Rs  in  5  source register of the instruction in ID.
- IFID_Rt  in  5  second source register of the instruction in ID.
- BranchTaken  in  1  EX resolved a taken branch/jump.
- MemReq  in  1  EX/MEM holds a valid load/store.
- MemReady  in  1  data memory completes the access this cycle.
- PC_EN  out  1  PC update enable.
- IFID_EN  out  1  IF/ID enable.
- IFID_FLUSH  out  1  IF/ID clear to NOP.
- IDEX_EN  out  1  ID/EX enable.
- IDEX_FLUSH  out  1  ID/EX clear to bubble.
- EXMEM_EN  out  1  EX/MEM enable.
- MEMWB_BUBBLE  out  1  force RegWriteEN=0 into MEM/WB.
- MemError  out  1  sticky memory-timeout flag.
- StallCycles  out  32  stall-cycle count (see Optional Feature).

Behaviour:
Reset and interface
- One clock; reset is asynchronous and active-low: CLOCK, RESET_N.
- While RESET_N=0:
  - state=INIT, timer=0, MemError=0, StallCycles=0.
  - PC_EN, IFID_EN, IDEX_EN, EXMEM_EN = 0.
  - IFID_FLUSH, IDEX_FLUSH, MEMWB_BUBBLE = 1.
- All outputs are combinational from state and inputs. The state, timer and counters are flops.

States
- INIT:
  - Exactly one cycle after RESET_N rises.
  - Outputs are held at their reset values.
  - Next state is RUN.
- RUN, priority high to low:
  1. Memory wait: MemReq=1 & MemReady=0.
     - Freeze: all *_EN=0, MEMWB_BUBBLE=1, flushes=0.
     - Next state MEM_WAIT; timer is loaded with 1.
  2. Branch: BranchTaken=1.
     - All EN=1, IFID_FLUSH=1, IDEX_FLUSH=1.
     - Branch overrides load-use because the dependent instruction is squashed.
  3. Load-use: IDEX_MemRead=1 & IDEX_Rt!=0 & (IDEX_Rt==IFID_Rs | IDEX_Rt==IFID_Rt).
     - PC_EN=0, IFID_EN=0, IDEX_FLUSH=1, EXMEM_EN=1.
     - Lasts one cycle only: the next cycle sees the bubble in EX.
  4. Otherwise all EN=1, flushes=0, MEMWB_BUBBLE=0.
- MEM_WAIT:
  - Freeze as in RUN priority 1. BranchTaken and load-use are ignored, because the pipeline is frozen and its inputs are stable.
  - MemReady=1: this cycle outputs the RUN normal/branch/load-use evaluation with MEMWB_BUBBLE=0. Next state RUN, timer=0.
  - Else, if timer==MEM_TIMEOUT:
    - Forced release: all EN=1, MEMWB_BUBBLE=1, so the failed load never writes back.
    - MemError is set to 1 (sticky until reset).
    - Next state RUN.
  - Else timer increments.
  - MemReady arriving on the timeout cycle counts as a normal completion, with no error.
- Reset asserted mid-MEM_WAIT aborts immediately to reset values.
- The timer never wraps, because the timeout check precedes the increment.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - StallCycles increments by 1 each cycle in RUN or MEM_WAIT where PC_EN=0.
  - It saturates at 32'hFFFF_FFFF.
  - INIT cycles are not counted.
- Undefined: StallCycles is constant 0 and no counter flops are inferred.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum {INIT, RUN, MEM_WAIT} as 2-bit localparams.
  - Defaults for MEM_TIMEOUT and TMR_W.
  - Register-zero constant 5'd0.
- Sub-module mem_wait_timer holds the load/increment/compare timer. Ports: CLOCK, RESET_N, load, inc, hit.
- Hazard compare and output decode stay in the top module.

Test Plan:
- Release reset -> exactly one INIT cycle (all EN=0, flushes=1), then PC_EN=1 with no flushes; MemError=0.
- IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle -> PC_EN=0, IFID_EN=0, IDEX_FLUSH=1 for one cycle. Repeat with IDEX_Rt=0 -> no stall.
- Load-use and BranchTaken=1 in the same cycle -> IFID_FLUSH=1, IDEX_FLUSH=1, PC_EN=1 (branch wins).
- MemReq=1, MemReady=0 for 4 cycles, then MemReady=1 -> 4 frozen cycles with MEMWB_BUBBLE=1, release on the 5th, MemError=0, StallCycles=4 (macro on).
- MEM_TIMEOUT=3, MemReady held 0 -> freeze, forced release with MEMWB_BUBBLE=1 on the 4th cycle, MemError=1 and staying set; RESET_N pulse clears it.
- RESET_N dropped during MEM_WAIT -> outputs go to reset values asynchronously, with no clock edge needed.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam int MEM_TIMEOUT_DEF = 255;
    localparam int TMR_W_DEF       = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_bubble;
    } ctrl_t;

    // Field order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_bubble
    localparam ctrl_t CTRL_RESET  = 7'b0010101;
    localparam ctrl_t CTRL_NORM   = 7'b1101010;
    localparam ctrl_t CTRL_LU     = 7'b0001110;
    localparam ctrl_t CTRL_BRANCH = 7'b1111110;
    localparam ctrl_t CTRL_FREEZE = 7'b0000001;
    localparam ctrl_t CTRL_FORCED = 7'b1101011;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on data memory; hit flags the timeout value.
module mem_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int TMR_W       = TMR_W_DEF
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic load,
    input  logic inc,
    output logic hit
);

    logic [TMR_W-1:0] timer;

    // Idle (neither load nor inc) returns the timer to zero.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            timer <= '0;
        else if (load)
            timer <= TMR_W'(1);
        else if (inc)
            timer <= timer + 1'b1;
        else
            timer <= '0;
    end

    assign hit = (timer == TMR_W'(MEM_TIMEOUT));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int TMR_W       = TMR_W_DEF
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        BranchTaken,
    input  logic        MemReq,
    input  logic        MemReady,
    output logic        PC_EN,
    output logic        IFID_EN,
    output logic        IFID_FLUSH,
    output logic        IDEX_EN,
    output logic        IDEX_FLUSH,
    output logic        EXMEM_EN,
    output logic        MEMWB_BUBBLE,
    output logic        MemError,
    output logic [31:0] StallCycles
);

    state_t state, state_nxt;
    ctrl_t  ctrl, run_ctrl;
    logic   load_use, mem_stall;
    logic   tmr_load, tmr_inc, tmr_hit, set_err;

    assign load_use  = IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
                       ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
    assign mem_stall = MemReq && !MemReady;

    // Branch squashes the dependent instruction, so it outranks load-use.
    always_comb begin
        if (BranchTaken)
            run_ctrl = CTRL_BRANCH;
        else if (load_use)
            run_ctrl = CTRL_LU;
        else
            run_ctrl = CTRL_NORM;
    end

    always_comb begin
        ctrl      = CTRL_RESET;
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_inc   = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_INIT: state_nxt = S_RUN;
            S_RUN: begin
                if (mem_stall) begin
                    ctrl      = CTRL_FREEZE;
                    state_nxt = S_MEM_WAIT;
                    tmr_load  = 1'b1;
                end else begin
                    ctrl = run_ctrl;
                end
            end
            S_MEM_WAIT: begin
                if (MemReady) begin
                    ctrl      = run_ctrl;
                    state_nxt = S_RUN;
                end else if (tmr_hit) begin
                    // Bubble keeps the failed load from writing back.
                    ctrl      = CTRL_FORCED;
                    state_nxt = S_RUN;
                    set_err   = 1'b1;
                end else begin
                    ctrl    = CTRL_FREEZE;
                    tmr_inc = 1'b1;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_INIT;
            MemError <= 1'b0;
        end else begin
            state <= state_nxt;
            if (set_err)
                MemError <= 1'b1;
        end
    end

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_timer (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .load    (tmr_load),
        .inc     (tmr_inc),
        .hit     (tmr_hit)
    );

    assign PC_EN        = ctrl.pc_en;
    assign IFID_EN      = ctrl.ifid_en;
    assign IFID_FLUSH   = ctrl.ifid_flush;
    assign IDEX_EN      = ctrl.idex_en;
    assign IDEX_FLUSH   = ctrl.idex_flush;
    assign EXMEM_EN     = ctrl.exmem_en;
    assign MEMWB_BUBBLE = ctrl.memwb_bubble;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            stall_cnt <= '0;
        else if ((state != S_INIT) && !ctrl.pc_en && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign StallCycles = stall_cnt;
`else
    assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: dut_a uses default timeout, dut_b uses MEM_TIMEOUT=3.
module tb_pipe_hazard_ctrl;

    logic       CLOCK;
    logic       RESET_N;
    logic       IDEX_MemRead, BranchTaken, MemReq, MemReady;
    logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;

    logic pc_a, ifen_a, iff_a, iden_a, idf_a, exen_a, bub_a, err_a;
    logic pc_b, ifen_b, iff_b, iden_b, idf_b, exen_b, bub_b, err_b;
    logic [31:0] st_a, st_b;

    pipe_hazard_ctrl dut_a (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .BranchTaken(BranchTaken), .MemReq(MemReq),
        .MemReady(MemReady), .PC_EN(pc_a), .IFID_EN(ifen_a), .IFID_FLUSH(iff_a),
        .IDEX_EN(iden_a), .IDEX_FLUSH(idf_a), .EXMEM_EN(exen_a), .MEMWB_BUBBLE(bub_a),
        .MemError(err_a), .StallCycles(st_a)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(3), .TMR_W(2)) dut_b (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .BranchTaken(BranchTaken), .MemReq(MemReq),
        .MemReady(MemReady), .PC_EN(pc_b), .IFID_EN(ifen_b), .IFID_FLUSH(iff_b),
        .IDEX_EN(iden_b), .IDEX_FLUSH(idf_b), .EXMEM_EN(exen_b), .MEMWB_BUBBLE(bub_b),
        .MemError(err_b), .StallCycles(st_b)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // {PC_EN, IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_FLUSH, EXMEM_EN, MEMWB_BUBBLE, MemError}
    localparam logic [7:0] RST  = 8'b00101010;
    localparam logic [7:0] NORM = 8'b11010100;
    localparam logic [7:0] LU   = 8'b00011100;
    localparam logic [7:0] BR   = 8'b11111100;
    localparam logic [7:0] FRZ  = 8'b00000010;
    localparam logic [7:0] REL  = 8'b11010110;
    localparam logic [7:0] ERR  = 8'b00000001;

    typedef struct {
        string       nm;
        bit          sel;
        logic [7:0]  e;
        bit          cs;
        logic [31:0] s;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    logic [7:0]  got;
    logic [31:0] gst;

    function automatic logic [31:0] stx(input int n);
`ifdef PIPE_STALL_CNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic expect_ctrl(input string nm, input bit sel, input logic [7:0] e);
        exp_t x;
        x.nm = nm; x.sel = sel; x.e = e; x.cs = 1'b0; x.s = '0;
        sb.push_back(x);
    endtask

    task automatic expect_st(input string nm, input bit sel, input logic [7:0] e, input int n);
        exp_t x;
        x.nm = nm; x.sel = sel; x.e = e; x.cs = 1'b1; x.s = stx(n);
        sb.push_back(x);
    endtask

    task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] rt2, input logic br, input logic mq, input logic rdy);
        IDEX_MemRead = mr; IDEX_Rt = rt; IFID_Rs = rs; IFID_Rt = rt2;
        BranchTaken = br; MemReq = mq; MemReady = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Monitor: outputs are valid every cycle; compare whatever is queued.
    always @(negedge CLOCK) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            got = cur.sel ? {pc_b, ifen_b, iff_b, iden_b, idf_b, exen_b, bub_b, err_b}
                          : {pc_a, ifen_a, iff_a, iden_a, idf_a, exen_a, bub_a, err_a};
            gst = cur.sel ? st_b : st_a;
            checks++;
            if (got !== cur.e) begin
                failures++;
                $display("FAIL %s: ctrl got %b want %b", cur.nm, got, cur.e);
            end
            if (cur.cs) begin
                checks++;
                if (gst !== cur.s) begin
                    failures++;
                    $display("FAIL %s: StallCycles got %0d want %0d", cur.nm, gst, cur.s);
                end
            end
        end
    end

    task automatic reset_pulse(input bit sel);
        RESET_N = 1'b0; idle();
        expect_st("reset_low", sel, RST, 0); tick();
        RESET_N = 1'b1;
        expect_ctrl("init_cycle", sel, RST); tick();
        expect_st("first_run", sel, NORM, 0); tick();
    endtask

    initial begin
        RESET_N = 1'b0; idle();
        tick();

        reset_pulse(1'b0);

        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0); expect_ctrl("lu_rs", 0, LU); tick();
        idle();                                          expect_ctrl("lu_one_cycle", 0, NORM); tick();
        drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0); expect_ctrl("lu_rt", 0, LU); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); expect_ctrl("lu_r0", 0, NORM); tick();
        drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0); expect_ctrl("no_load", 0, NORM); tick();
        drive(1'b1, 5'd5, 5'd6, 5'd4, 1'b0, 1'b0, 1'b0); expect_ctrl("no_match", 0, NORM); tick();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0); expect_ctrl("br_over_lu", 0, BR); tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); expect_ctrl("branch", 0, BR); tick();
        idle();                                          expect_ctrl("after_br", 0, NORM); tick();

        // Memory wait with branch/load-use present: freeze, then release evaluates branch.
        reset_pulse(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
            expect_st("mem_freeze", 0, FRZ, i); tick();
        end
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1); expect_st("mem_release", 0, BR, 4); tick();
        idle();                                          expect_st("after_wait", 0, NORM, 4); tick();

        // Timeout on dut_b (MEM_TIMEOUT=3).
        reset_pulse(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            expect_st("to_freeze", 1, FRZ, i); tick();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); expect_st("to_forced", 1, REL, 3); tick();
        idle();                                          expect_st("err_set", 1, NORM | ERR, 3); tick();
        idle();                                          expect_ctrl("err_sticky", 1, NORM | ERR); tick();

        // Reset clears error; MemReady on the timeout cycle is a normal completion.
        reset_pulse(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            expect_ctrl("rdy_freeze", 1, FRZ); tick();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); expect_st("rdy_at_timeout", 1, NORM, 3); tick();
        idle();                                          expect_ctrl("no_err", 1, NORM); tick();

        // Asynchronous reset in the middle of a memory wait.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            expect_ctrl("pre_abort", 0, FRZ); tick();
        end
        RESET_N = 1'b0;
        expect_st("async_abort_a", 0, RST, 0);
        expect_st("async_abort_b", 1, RST, 0);
        tick();
        idle(); RESET_N = 1'b1;
        expect_ctrl("abort_init", 0, RST); tick();
        expect_ctrl("abort_run", 0, NORM); tick();

        @(negedge CLOCK);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left %0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
